// File: rtl/tpu_host_seq.sv
// Host-side command sequencer for the TPU core's memory-mapped port.
// Takes one command at a time over a valid/ready channel and replays it as
// the address / r_w / data pattern the core decoder expects, including the
// per-command hold times, the post-multiply busy window and a one-cycle gap
// between commands. Bus outputs are registered so they change only on edges.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds valid (and payload) stable until that edge,
// and ready never depends combinationally on valid.
module tpu_host_seq #(
  parameter int ADDRW     = 16,
  parameter int DATAW     = 64,
  parameter int MM_CYCLES = 23,
  parameter int C_WR_HOLD = 3,
  parameter int C_RD_HOLD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [2:0]       cmd_row,
  input  logic             cmd_half,
  input  logic [DATAW-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DATAW-1:0] rsp_data,
  output logic             busy,
  output logic             err,
  output logic             tpu_r_w,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_dataIn,
  input  logic [DATAW-1:0] tpu_dataOut
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_MM = 3'd2,
    RESP    = 3'd3,
    GAP     = 3'd4
  } state_t;

  localparam logic [2:0] OP_WR_A   = 3'd0;
  localparam logic [2:0] OP_WR_B   = 3'd1;
  localparam logic [2:0] OP_WR_C   = 3'd2;
  localparam logic [2:0] OP_RD_C   = 3'd3;
  localparam logic [2:0] OP_MATMUL = 3'd4;

  // Counter preload values are "cycles minus one": the counter reaches zero
  // on the final cycle of the phase.
  localparam logic [4:0] WR_C_LOAD = 5'(C_WR_HOLD - 1);
  localparam logic [4:0] RD_C_LOAD = 5'(C_RD_HOLD - 1);
  localparam logic [4:0] MM_LOAD   = 5'(MM_CYCLES - 1);

  state_t           state_q;
  logic [2:0]       op_q;
  logic [4:0]       cnt_q;
  logic             r_w_q;
  logic [ADDRW-1:0] addr_q;
  logic [DATAW-1:0] din_q;
  logic [DATAW-1:0] rsp_data_q;
  logic             err_q;

  logic [15:0]      dec_addr;
  logic [4:0]       dec_hold;
  logic             dec_legal;
  logic             dec_write_data;

  // Decode the incoming command into its core address and hold length.
  always_comb begin
    dec_addr       = 16'h0000;
    dec_hold       = 5'd0;
    dec_legal      = 1'b1;
    dec_write_data = 1'b0;
    case (cmd_op)
      OP_WR_A: begin
        dec_addr       = 16'h0100 + {10'd0, cmd_row, 3'b000};
        dec_write_data = 1'b1;
      end
      OP_WR_B: begin
        dec_addr       = 16'h0200 + {10'd0, cmd_row, 3'b000};
        dec_write_data = 1'b1;
      end
      OP_WR_C: begin
        dec_addr       = 16'h0300 + {9'd0, cmd_row, cmd_half, 3'b000};
        dec_hold       = WR_C_LOAD;
        dec_write_data = 1'b1;
      end
      OP_RD_C: begin
        dec_addr = 16'h0300 + {9'd0, cmd_row, cmd_half, 3'b000};
        dec_hold = RD_C_LOAD;
      end
      OP_MATMUL: dec_addr = 16'h0400;
      default:   dec_legal = 1'b0;
    endcase
  end

  // Sequencer FSM: one shared down-counter times both the bus hold and the
  // multiply busy window; bus outputs are loaded on transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= 3'd0;
      cnt_q      <= 5'd0;
      r_w_q      <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q <= cmd_op;
            if (dec_legal) begin
              state_q <= ISSUE;
              cnt_q   <= dec_hold;
              addr_q  <= ADDRW'(dec_addr);
              r_w_q   <= (cmd_op != OP_RD_C);
              din_q   <= dec_write_data ? cmd_data : '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (cnt_q == 5'd0) begin
            addr_q <= '0;
            r_w_q  <= 1'b0;
            din_q  <= '0;
            if (op_q == OP_MATMUL) begin
              state_q <= WAIT_MM;
              cnt_q   <= MM_LOAD;
            end else if (op_q == OP_RD_C) begin
              // The core's read data is valid on the last address-hold cycle.
              rsp_data_q <= tpu_dataOut;
              state_q    <= RESP;
            end else begin
              state_q <= GAP;
            end
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        WAIT_MM: begin
          if (cnt_q == 5'd0) state_q <= GAP;
          else               cnt_q   <= cnt_q - 5'd1;
        end
        RESP: begin
          if (rsp_ready) state_q <= GAP;
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_data   = rsp_data_q;
  assign err        = err_q;
  assign tpu_r_w    = r_w_q;
  assign tpu_addr   = addr_q;
  assign tpu_dataIn = din_q;

endmodule

// File: tb/tb_tpu_host_seq.sv
// Directed bench for tpu_host_seq: walks each command type, the response
// stall, an illegal opcode and a mid-command reset against a tiny core model.
module tb_tpu_host_seq;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_row;
  logic        cmd_half;
  logic [63:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        busy;
  logic        err;
  logic        tpu_r_w;
  logic [15:0] tpu_addr;
  logic [63:0] tpu_dataIn;
  logic [63:0] tpu_dataOut;

  int checks = 0;
  int errors = 0;

  tpu_host_seq dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_row    (cmd_row),
    .cmd_half   (cmd_half),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .err        (err),
    .tpu_r_w    (tpu_r_w),
    .tpu_addr   (tpu_addr),
    .tpu_dataIn (tpu_dataIn),
    .tpu_dataOut(tpu_dataOut)
  );

  // Clock / core read model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tpu_dataOut = (tpu_addr == 16'h0370 && !tpu_r_w) ? 64'hDEADBEEF00000001
                                                          : {32'hC0DE0000, 16'h0000, tpu_addr};

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] row, input logic half,
                      input logic [63:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_row   = row;
    cmd_half  = half;
    cmd_data  = data;
  endtask

  task automatic chk_bus(input string tag, input logic [15:0] a, input logic rw,
                         input logic [63:0] d);
    chk({tag, "_addr"}, 64'(tpu_addr), 64'(a));
    chk({tag, "_rw"}, 64'(tpu_r_w), 64'(rw));
    chk({tag, "_din"}, tpu_dataIn, d);
  endtask

  initial begin
    int n;
    int idle_bad;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_row = 3'd0; cmd_half = 1'b0;
    cmd_data = 64'd0; rsp_ready = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rspv", 64'(rsp_valid), 64'd0);
    chk("rst_rspd", rsp_data, 64'd0);
    chk_bus("rst", 16'h0000, 1'b0, 64'd0);

    // WR_A row 5
    send(3'd0, 3'd5, 1'b0, 64'h0102030405060708);
    step(); cmd_valid = 1'b0;
    chk_bus("wra_issue", 16'h0128, 1'b1, 64'h0102030405060708);
    chk("wra_busy", 64'(busy), 64'd1);
    chk("wra_ready0", 64'(cmd_ready), 64'd0);
    step();
    chk_bus("wra_gap", 16'h0000, 1'b0, 64'd0);
    chk("wra_gap_ready", 64'(cmd_ready), 64'd0);
    step();
    chk("wra_ready_back", 64'(cmd_ready), 64'd1);

    // WR_C row 2 half 1: three hold cycles
    send(3'd2, 3'd2, 1'b1, 64'h000000000000AAAA);
    step(); cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_bus($sformatf("wrc_hold%0d", i), 16'h0328, 1'b1, 64'h000000000000AAAA);
      step();
    end
    chk_bus("wrc_gap", 16'h0000, 1'b0, 64'd0);
    chk("wrc_gap_ready", 64'(cmd_ready), 64'd0);
    step();
    chk("wrc_ready_back", 64'(cmd_ready), 64'd1);

    // RD_C row 7 half 0 with a 4-cycle response stall
    send(3'd3, 3'd7, 1'b0, 64'hFFFF);
    step(); cmd_valid = 1'b0;
    chk_bus("rdc_hold0", 16'h0370, 1'b0, 64'd0);
    step();
    chk_bus("rdc_hold1", 16'h0370, 1'b0, 64'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rdc_stall%0d_rspv", i), 64'(rsp_valid), 64'd1);
      chk($sformatf("rdc_stall%0d_rspd", i), rsp_data, 64'hDEADBEEF00000001);
      chk($sformatf("rdc_stall%0d_ready", i), 64'(cmd_ready), 64'd0);
      chk($sformatf("rdc_stall%0d_addr", i), 64'(tpu_addr), 64'd0);
      if (i < 3) step();
    end
    rsp_ready = 1'b1;
    step();
    chk("rdc_gap_rspv", 64'(rsp_valid), 64'd0);
    chk("rdc_gap_ready", 64'(cmd_ready), 64'd0);
    chk("rdc_hold_rspd", rsp_data, 64'hDEADBEEF00000001);
    step();
    chk("rdc_ready_back", 64'(cmd_ready), 64'd1);

    // RD_C row 0 half 1 with rsp_ready already high: one-cycle response
    send(3'd3, 3'd0, 1'b1, 64'd0);
    step(); cmd_valid = 1'b0;
    chk_bus("rdc2_hold0", 16'h0308, 1'b0, 64'd0);
    step(); step();
    chk("rdc2_rspv", 64'(rsp_valid), 64'd1);
    chk("rdc2_rspd", rsp_data, 64'hC0DE000000000308);
    step();
    chk("rdc2_rspv_drop", 64'(rsp_valid), 64'd0);
    step();
    rsp_ready = 1'b0;
    chk("rdc2_ready_back", 64'(cmd_ready), 64'd1);

    // MATMUL, with a WR_B row 3 held pending the whole time
    send(3'd4, 3'd0, 1'b0, 64'h1234);
    step();
    send(3'd1, 3'd3, 1'b0, 64'h5555666677778888);
    chk_bus("mm_issue", 16'h0400, 1'b1, 64'd0);
    chk("mm_busy", 64'(busy), 64'd1);
    n = 1;
    idle_bad = 0;
    while (!cmd_ready && n < 60) begin
      step();
      n++;
      if (tpu_addr !== 16'h0000 || tpu_r_w !== 1'b0 || tpu_dataIn !== 64'd0) idle_bad++;
      if (!cmd_ready && busy !== 1'b1) idle_bad++;
    end
    chk("mm_occupancy", 64'(n), 64'd26);
    chk("mm_idle_bus", 64'(idle_bad), 64'd0);
    step(); cmd_valid = 1'b0;
    chk_bus("wrb_issue", 16'h0218, 1'b1, 64'h5555666677778888);
    step();
    chk_bus("wrb_gap", 16'h0000, 1'b0, 64'd0);
    step();
    chk("wrb_ready_back", 64'(cmd_ready), 64'd1);

    // Illegal opcode 6
    send(3'd6, 3'd1, 1'b0, 64'h77);
    step(); cmd_valid = 1'b0;
    chk("ill_err", 64'(err), 64'd1);
    chk("ill_ready", 64'(cmd_ready), 64'd1);
    chk("ill_busy", 64'(busy), 64'd0);
    chk("ill_addr", 64'(tpu_addr), 64'd0);
    step();
    chk("ill_err_drop", 64'(err), 64'd0);
    chk("ill_addr2", 64'(tpu_addr), 64'd0);

    // Reset during the second WR_C hold cycle
    send(3'd2, 3'd1, 1'b0, 64'hBEEF);
    step(); cmd_valid = 1'b0;
    chk("rstmid_hold0", 64'(tpu_addr), 64'h0310);
    step();
    chk("rstmid_hold1", 64'(tpu_addr), 64'h0310);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_bus("rstmid", 16'h0000, 1'b0, 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_ready", 64'(cmd_ready), 64'd1);
    chk("rstmid_rspv", 64'(rsp_valid), 64'd0);

    // Normal operation after the abort: WR_A row 0
    send(3'd0, 3'd0, 1'b0, 64'h0F0F);
    step(); cmd_valid = 1'b0;
    chk_bus("post_wra", 16'h0100, 1'b1, 64'h0F0F);
    step(); step();
    chk("post_ready", 64'(cmd_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
